// File: rtl/fifo_sync_param.sv
// Single-clock FIFO over a 2^DEPTH_LOG2 x WIDTH dual-port RAM; registered flags, q one cycle after read (or head word with SHOWAHEAD).
// Writes to a full FIFO are dropped unless a read frees a slot that cycle; reads from empty are ignored; both raise sticky error flags.
module fifo_sync_param #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int SHOWAHEAD  = 0,
    parameter int AF_LEVEL   = 2**DEPTH_LOG2 - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk_24mhz,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [WIDTH-1:0]      data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    output logic [WIDTH-1:0]      q,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);
    localparam logic [LW-1:0] LVL_AE   = LW'(AE_LEVEL);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [WIDTH-1:0]      q_reg;
    logic [LW-1:0]         level_nxt;
    logic                  rd_acc;
    logic                  wr_acc;

    // clr wins over both requests, so it also blocks acceptance
    assign rd_acc = rdreq & ~empty & ~clr;
    assign wr_acc = wrreq & ~clr & (~full | rd_acc);

    always_comb begin
        level_nxt = level;
        if (clr) begin
            level_nxt = '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   level_nxt = level + LW'(1);
                2'b01:   level_nxt = level - LW'(1);
                default: level_nxt = level;
            endcase
        end
    end

    // Flags are registered from the next level so they always match level exactly
    always_ff @(posedge clk_24mhz or posedge rst) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            level        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (clr) begin
                wptr      <= '0;
                rptr      <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (wr_acc)
                    wptr <= wptr + DEPTH_LOG2'(1);
                if (rd_acc)
                    rptr <= rptr + DEPTH_LOG2'(1);
                if (wrreq && !wr_acc)
                    overflow <= 1'b1;
                if (rdreq && empty)
                    underflow <= 1'b1;
            end
            level        <= level_nxt;
            empty        <= (level_nxt == '0);
            full         <= (level_nxt == LVL_FULL);
            almost_full  <= (level_nxt >= LVL_AF);
            almost_empty <= (level_nxt <= LVL_AE);
        end
    end

    always_ff @(posedge clk_24mhz) begin
        if (wr_acc && !rst)
            mem[wptr] <= data;
    end

    // Showahead keeps a copy of the head so q stays stable once the FIFO drains
    always_ff @(posedge clk_24mhz or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
        end else if (SHOWAHEAD != 0) begin
            if (!empty)
                q_reg <= mem[rptr];
        end else if (rd_acc) begin
            q_reg <= mem[rptr];
        end
    end

    // Asynchronous RAM read makes a word written into an empty FIFO visible as soon as empty drops
    assign q = (SHOWAHEAD != 0 && !empty) ? mem[rptr] : q_reg;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: default, showahead and small-depth instances.
module tb_fifo_sync_param;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        rst = 1'b0;

    logic        clr = 1'b0, wrreq = 1'b0, rdreq = 1'b0;
    logic [15:0] data = '0, q;
    logic        empty, full, ae, af, ovf, udf;
    logic [8:0]  level;

    logic        sa_clr = 1'b0, sa_wrreq = 1'b0, sa_rdreq = 1'b0;
    logic [15:0] sa_data = '0, sa_q;
    logic        sa_empty, sa_full, sa_ae, sa_af, sa_ovf, sa_udf;
    logic [8:0]  sa_level;

    logic        sm_clr = 1'b0, sm_wrreq = 1'b0, sm_rdreq = 1'b0;
    logic [7:0]  sm_data = '0, sm_q;
    logic        sm_empty, sm_full, sm_ae, sm_af, sm_ovf, sm_udf;
    logic [4:0]  sm_level;

    fifo_sync_param u_dut (
        .clk_24mhz(clk), .rst(rst), .clr(clr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(q), .empty(empty), .full(full), .almost_empty(ae), .almost_full(af),
        .level(level), .overflow(ovf), .underflow(udf)
    );

    fifo_sync_param #(.SHOWAHEAD(1)) u_sa (
        .clk_24mhz(clk), .rst(rst), .clr(sa_clr), .data(sa_data), .wrreq(sa_wrreq), .rdreq(sa_rdreq),
        .q(sa_q), .empty(sa_empty), .full(sa_full), .almost_empty(sa_ae), .almost_full(sa_af),
        .level(sa_level), .overflow(sa_ovf), .underflow(sa_udf)
    );

    fifo_sync_param #(.WIDTH(8), .DEPTH_LOG2(4)) u_sm (
        .clk_24mhz(clk), .rst(rst), .clr(sm_clr), .data(sm_data), .wrreq(sm_wrreq), .rdreq(sm_rdreq),
        .q(sm_q), .empty(sm_empty), .full(sm_full), .almost_empty(sm_ae), .almost_full(sm_af),
        .level(sm_level), .overflow(sm_ovf), .underflow(sm_udf)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] sb[$];
    logic [15:0] last_q = '0;
    bit          m_ovf  = 1'b0;
    bit          m_udf  = 1'b0;

    // Drive one cycle on the default instance, advance the model, compare everything
    task automatic step(input bit wr, input bit rd, input logic [15:0] d);
        bit ra, wa;
        int n;
        wrreq = wr;
        rdreq = rd;
        data  = d;
        ra = rd && (sb.size() > 0);
        wa = wr && ((sb.size() < 256) || ra);
        if (rd && sb.size() == 0) m_udf = 1'b1;
        if (wr && !wa)            m_ovf = 1'b1;
        if (ra) last_q = sb.pop_front();
        if (wa) sb.push_back(d);
        tick;
        wrreq = 1'b0;
        rdreq = 1'b0;
        n = sb.size();
        check(ra ? "q_read" : "q_hold", 32'(q), 32'(last_q));
        check("level", 32'(level), 32'(n));
        check("empty", 32'(empty), 32'(n == 0));
        check("full",  32'(full),  32'(n == 256));
        check("almost_full",  32'(af), 32'(n >= 252));
        check("almost_empty", 32'(ae), 32'(n <= 4));
        check("overflow",  32'(ovf), 32'(m_ovf));
        check("underflow", 32'(udf), 32'(m_udf));
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_level", 32'(level), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full",  32'(full), 0);
        check("rst_ae",    32'(ae), 1);
        check("rst_af",    32'(af), 0);
        check("rst_ovf",   32'(ovf), 0);
        check("rst_udf",   32'(udf), 0);
        check("rst_q",     32'(q), 0);
        tick;
        tick;
        rst = 1'b0;

        // Showahead: head visible without a read
        sa_wrreq = 1'b1; sa_data = 16'hA5A5;
        tick;
        sa_wrreq = 1'b0;
        check("sa_empty", 32'(sa_empty), 0);
        check("sa_q_first", 32'(sa_q), 32'h0000A5A5);
        check("sa_level", 32'(sa_level), 1);
        sa_wrreq = 1'b1; sa_data = 16'h1234;
        tick;
        sa_wrreq = 1'b0;
        check("sa_q_head_kept", 32'(sa_q), 32'h0000A5A5);
        sa_rdreq = 1'b1;
        tick;
        check("sa_q_next", 32'(sa_q), 32'h00001234);
        tick;
        sa_rdreq = 1'b0;
        check("sa_drained", 32'(sa_empty), 1);
        check("sa_q_held", 32'(sa_q), 32'h00001234);
        check("sa_udf", 32'(sa_udf), 0);

        // Small FIFO: clr overrides a concurrent write and clears sticky flags
        sm_rdreq = 1'b1;
        tick;
        sm_rdreq = 1'b0;
        check("sm_udf_set", 32'(sm_udf), 1);
        for (int i = 0; i < 10; i++) begin
            sm_wrreq = 1'b1; sm_data = 8'(i + 16);
            tick;
        end
        sm_wrreq = 1'b0;
        check("sm_level10", 32'(sm_level), 10);
        check("sm_af10", 32'(sm_af), 0);
        sm_clr = 1'b1; sm_wrreq = 1'b1; sm_data = 8'hFF;
        tick;
        sm_clr = 1'b0; sm_wrreq = 1'b0;
        check("sm_clr_level", 32'(sm_level), 0);
        check("sm_clr_empty", 32'(sm_empty), 1);
        check("sm_clr_ovf", 32'(sm_ovf), 0);
        check("sm_clr_udf", 32'(sm_udf), 0);
        for (int i = 0; i < 17; i++) begin
            sm_wrreq = 1'b1; sm_data = 8'(i);
            tick;
        end
        sm_wrreq = 1'b0;
        check("sm_full", 32'(sm_full), 1);
        check("sm_level16", 32'(sm_level), 16);
        check("sm_ovf_set", 32'(sm_ovf), 1);
        sm_rdreq = 1'b1;
        tick;
        sm_rdreq = 1'b0;
        check("sm_q_first", 32'(sm_q), 0);

        // Default: fill, concurrent rd/wr while full, overflow, drain, underflow
        for (int i = 1; i <= 256; i++)
            step(1'b1, 1'b0, 16'(i));
        for (int k = 0; k < 10; k++)
            step(1'b1, 1'b1, 16'(16'h8000 + k));
        step(1'b1, 1'b0, 16'hDEAD);
        for (int i = 0; i < 256; i++)
            step(1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b1, 16'h0);

        // Reset mid-burst at level 37
        for (int i = 0; i < 37; i++)
            step(1'b1, 1'b0, 16'(16'h4000 + i));
        #3;
        rst = 1'b1; wrreq = 1'b1; data = 16'h0BAD;
        #1;
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_full",  32'(full), 0);
        check("mid_rst_ae",    32'(ae), 1);
        check("mid_rst_af",    32'(af), 0);
        check("mid_rst_ovf",   32'(ovf), 0);
        check("mid_rst_udf",   32'(udf), 0);
        check("mid_rst_q",     32'(q), 0);
        sb.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        last_q = '0;
        tick;
        check("rst_ignores_wr", 32'(level), 0);
        rst = 1'b0;
        wrreq = 1'b0;
        step(1'b1, 1'b0, 16'h7001);
        step(1'b1, 1'b0, 16'h7002);
        step(1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b1, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, storage depth of 2^DEPTH_LOG2 words.
REQ-003 SHALL have parameter SHOWAHEAD, default 0; 1 = head word presented on q without a read.
REQ-004 SHALL have parameter AF_LEVEL, default 2^DEPTH_LOG2-4, almost_full threshold.
REQ-005 SHALL have parameter AE_LEVEL, default 4, almost_empty threshold.
REQ-006 clk_24mhz  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 clr  input  1  synchronous flush.
REQ-009 data  input  WIDTH  write word.
REQ-010 wrreq  input  1  write request.
REQ-011 rdreq  input  1  read request.
REQ-012 q  output  WIDTH  read word.
REQ-013 empty, full  output  1 each  occupancy flags.
REQ-014 almost_empty, almost_full  output  1 each  threshold flags.
REQ-015 level  output  DEPTH_LOG2+1  current word count.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Storage SHALL be a 2^DEPTH_LOG2 x WIDTH dual-port RAM with write and read pointers of DEPTH_LOG2 bits, wrapping modulo depth.
REQ-018 A write SHALL be accepted when wrreq=1 and (full=0 or an accepted read occurs in the same cycle); accepted write stores data at wptr, wptr+1.
REQ-019 A read SHALL be accepted when rdreq=1 and empty=0; accepted read advances rptr+1.
REQ-020 level SHALL update next cycle: +1 write-only, -1 read-only, unchanged for both or neither.
REQ-021 empty SHALL equal (level==0); full SHALL equal (level==2^DEPTH_LOG2); both registered from level, no combinational path from requests.
REQ-022 almost_full SHALL equal (level>=AF_LEVEL); almost_empty SHALL equal (level<=AE_LEVEL).
REQ-023 SHOWAHEAD=0: q SHALL present the word read exactly one cycle after the accepted read and hold otherwise.
REQ-024 SHOWAHEAD=1: q SHALL present the head word whenever empty=0, including the first cycle empty deasserts after a write into an empty FIFO (write-through bypass); q undefined-but-stable-held while empty=1.
REQ-025 wrreq while full with no accepted read SHALL be dropped, pointers unchanged, and overflow set to 1.
REQ-026 rdreq while empty SHALL be ignored and underflow set to 1; simultaneous wrreq on empty SHALL still be accepted.
REQ-027 overflow and underflow SHALL remain 1 until rst or clr.
REQ-028 clr SHALL, next cycle, zero pointers, level, overflow, underflow; clr overrides wrreq/rdreq in same cycle; RAM contents untouched.
REQ-029 Write-to-read visibility: a word written in cycle N SHALL be readable (empty=0) from cycle N+1.

Reset
REQ-030 rst=1 SHALL immediately force: pointers 0, level 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, q 0.
REQ-031 rst asserted mid-operation SHALL discard all content; RAM contents not cleared; requests ignored while rst=1.

Verification
REQ-032 Default params, write 0x0001..0x0100 (256 words) -> full=1 after 256th, level=256, almost_full from level 252, then extra write -> overflow=1, level 256.
REQ-033 Read all 256 (SHOWAHEAD=0) -> q sequence 0x0001..0x0100 each one cycle after rdreq, empty=1 after last, extra rdreq -> underflow=1.
REQ-034 Full FIFO, wrreq=rdreq=1 for 10 cycles -> level stays 256, no overflow, pointers wrap, data order preserved.
REQ-035 SHOWAHEAD=1, single write 0xA5A5 into empty -> next cycle empty=0, q=0xA5A5 without rdreq.
REQ-036 WIDTH=8, DEPTH_LOG2=4: write 10, clr with wrreq=1 same cycle -> level 0, empty 1, overflow/underflow 0.
REQ-037 rst pulse mid-burst at level 37 -> all outputs at reset values within the same cycle, subsequent write/read returns new data only.
